power_pack_ctrl: RTL and testbench
==================================

# power_pack_ctrl

Consumer-side controller for the power-pack spawner. It decides when a pack is spawned by pulsing `spawn`, and it watches the puck for overlap with the displayed pack. On a hit it pulses `eaten`, latches the pack's `mode` and the current puck owner, and then runs the timed effect that the paddle and puck logic read back. It sits between the spawner (whose `rx`/`ry`/`mode` it consumes) and the game-logic blocks, all on the single pixel clock.

## Interface
Parameters:
- `PACK_W`, 20, pack width in pixels; must match the spawner.
- `PACK_H`, 20, pack height in pixels; must match the spawner.
- `PUCK_SIZE`, 16, puck square side in pixels.
- `EFFECT_FRAMES`, 300, effect duration in frames; range 1..1023.
- `COOLDOWN_FRAMES`, 120, frames from end of effect (or reset) to next spawn; range 1..1023.
- `TIMEOUT_FRAMES`, 600, frames an uncollected pack stays up; used only with `PP_TIMEOUT_EN`.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame.
- `px` in 11: puck top-left x.
- `py` in 10: puck top-left y.
- `owner` in 1: player who last touched the puck.
- `rx` in 11: pack x from the spawner.
- `ry` in 10: pack y from the spawner.
- `mode` in 2: pack type from the spawner; 00 shrink, 01 boost, 10 extra, 11 shield.
- `spawn` out 1: one-cycle spawn request.
- `eaten` out 1: one-cycle collected/hide pulse.
- `effect_active` out 1: a timed effect is running.
- `effect_mode` out 2: latched mode of the running effect.
- `effect_owner` out 1: latched owner of the running effect.
- `extra_pulse` out 1: one-cycle bonus pulse on collecting an EXTRA pack.
- `frames_left` out 10: remaining effect frames; 0 when no effect is running.

## Operation
- States: COOLDOWN, SPAWN, ARMED, EFFECT.
- Reset: state COOLDOWN, all counters 0, every output 0.
- COOLDOWN:
  - Counter increments on each `frame_tick`.
  - The tick that brings the counter to `COOLDOWN_FRAMES` moves the state to SPAWN.
- SPAWN: `spawn`=1 for exactly this cycle and `eaten`=0; always moves to ARMED.
- ARMED: each cycle, overlap is evaluated as
  - (`px` < `rx`+`PACK_W`) and (`px`+`PUCK_SIZE` > `rx`) and (`py` < `ry`+`PACK_H`) and (`py`+`PUCK_SIZE` > `ry`).
  - All sums are computed 12 bits wide, so there is no wrap near the screen edges.
- Hit in ARMED:
  - Next cycle `eaten`=1 for one cycle.
  - `effect_mode`←`mode` and `effect_owner`←`owner`, both sampled on the hit cycle.
  - If `mode`≠10: `frames_left`←`EFFECT_FRAMES` and the state moves to EFFECT.
  - If `mode`=10: `extra_pulse`=1 for one cycle (coincident with `eaten`), and the state moves to COOLDOWN with the counter cleared.
- EFFECT:
  - `effect_active`=1.
  - `frames_left` decrements on each `frame_tick`.
  - The tick at `frames_left`=1 clears `frames_left` to 0, deasserts `effect_active` and moves the state to COOLDOWN with the counter cleared.
- `spawn` and `eaten` are never high in the same cycle.
- Overlap is ignored in every state except ARMED.

## Timing
- All outputs are registered.
- Hit-cycle to `eaten`/`effect_active` latency: 1 cycle.
- `frame_tick` to counter update latency: 1 cycle.
- Hit and `frame_tick` in the same ARMED cycle: the hit wins and the tick is discarded. `frames_left` loads `EFFECT_FRAMES` without a decrement.
- `effect_mode`/`effect_owner` hold their value through COOLDOWN until the next hit. They are meaningful only while `effect_active` or `extra_pulse` is high.
- `reset` mid-effect: the effect ends immediately with all outputs 0; the next spawn occurs after a full `COOLDOWN_FRAMES`.
- `frame_tick` held high for more than one cycle counts once per cycle; frame-level callers must supply clean one-cycle pulses.

## Configuration
- Macro `PP_TIMEOUT_EN`.
- Defined: ARMED counts `frame_tick`s. When the count reaches `TIMEOUT_FRAMES` with no hit:
  - `eaten`=1 for one cycle to hide the pack;
  - no effect starts and `extra_pulse` stays 0;
  - state moves to COOLDOWN with the counter cleared.
  - A hit on the same cycle as the timeout tick takes priority over the timeout.
- Undefined: ARMED persists until a hit; the timeout counter and `TIMEOUT_FRAMES` are absent.

## Test plan
- Spawn timing: reset, then 120 `frame_tick`s -> `spawn` is a single-cycle pulse one cycle after the 120th tick; `eaten` stays 0 throughout.
- Boost hit: `rx`=700, `ry`=500, `mode`=01, `owner`=1; puck moved from `px`=600 to `px`=690 with `py`=505 -> `eaten` pulse; `effect_active`=1, `effect_mode`=01, `effect_owner`=1, `frames_left`=300. After 300 ticks `effect_active`=0, then the next `spawn` follows 120 ticks later.
- Edge non-overlap: `px`=684 (`px`+16=`rx`) and `py`=505 -> no `eaten`; `px`=685 -> `eaten`.
- EXTRA hit: `mode`=10 -> `eaten` and `extra_pulse` coincident for one cycle; `effect_active` stays 0; next `spawn` after 120 ticks.
- Simultaneous events:
  - Hit with `frame_tick` on the same cycle -> `frames_left`=300, not 299.
  - `reset` asserted with `frames_left`=150 -> all outputs 0 immediately.
- With `PP_TIMEOUT_EN`: no hit for 600 ticks in ARMED -> `eaten` pulse, no effect, then `spawn` again after 120 ticks.

Source files
------------

// File: rtl/power_pack_ctrl.sv
// Power-pack consumer: schedules spawns, detects puck/pack overlap, runs the timed effect.
// Define PP_TIMEOUT_EN to hide an uncollected pack after TIMEOUT_FRAMES.
module power_pack_ctrl #(
    parameter int unsigned PACK_W          = 20,
    parameter int unsigned PACK_H          = 20,
    parameter int unsigned PUCK_SIZE       = 16,
    parameter int unsigned EFFECT_FRAMES   = 300,
    parameter int unsigned COOLDOWN_FRAMES = 120
`ifdef PP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_FRAMES  = 600
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [10:0] px,
    input  logic [9:0]  py,
    input  logic        owner,
    input  logic [10:0] rx,
    input  logic [9:0]  ry,
    input  logic [1:0]  mode,
    output logic        spawn,
    output logic        eaten,
    output logic        effect_active,
    output logic [1:0]  effect_mode,
    output logic        effect_owner,
    output logic        extra_pulse,
    output logic [9:0]  frames_left
);

    localparam logic [1:0] ModeExtra = 2'b10;

    typedef enum logic [1:0] {StCooldown, StSpawn, StArmed, StEffect} state_e;

    state_e     state;
    logic [9:0] cool_cnt;
    logic       hit;

`ifdef PP_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_FRAMES + 1);
    logic [ToW-1:0] armed_cnt;
`endif

    // 12-bit sums keep the comparisons free of wrap at the screen edges.
    logic [11:0] px_w, py_w, rx_w, ry_w;
    assign px_w = {1'b0, px};
    assign py_w = {2'b00, py};
    assign rx_w = {1'b0, rx};
    assign ry_w = {2'b00, ry};

    assign hit = (px_w < rx_w + 12'(PACK_W)) && (px_w + 12'(PUCK_SIZE) > rx_w) &&
                 (py_w < ry_w + 12'(PACK_H)) && (py_w + 12'(PUCK_SIZE) > ry_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StCooldown;
            cool_cnt      <= '0;
            frames_left   <= '0;
            spawn         <= 1'b0;
            eaten         <= 1'b0;
            effect_active <= 1'b0;
            effect_mode   <= '0;
            effect_owner  <= 1'b0;
            extra_pulse   <= 1'b0;
`ifdef PP_TIMEOUT_EN
            armed_cnt     <= '0;
`endif
        end else begin
            spawn       <= 1'b0;
            eaten       <= 1'b0;
            extra_pulse <= 1'b0;
            unique case (state)
                StCooldown: begin
                    if (frame_tick) begin
                        if (cool_cnt == 10'(COOLDOWN_FRAMES - 1)) begin
                            cool_cnt <= '0;
                            spawn    <= 1'b1;
                            state    <= StSpawn;
                        end else begin
                            cool_cnt <= cool_cnt + 10'd1;
                        end
                    end
                end
                StSpawn: begin
                    state <= StArmed;
`ifdef PP_TIMEOUT_EN
                    armed_cnt <= '0;
`endif
                end
                StArmed: begin
                    // A hit always beats a coincident frame tick (and the timeout).
                    if (hit) begin
                        eaten        <= 1'b1;
                        effect_mode  <= mode;
                        effect_owner <= owner;
                        if (mode == ModeExtra) begin
                            extra_pulse <= 1'b1;
                            cool_cnt    <= '0;
                            state       <= StCooldown;
                        end else begin
                            frames_left   <= 10'(EFFECT_FRAMES);
                            effect_active <= 1'b1;
                            state         <= StEffect;
                        end
                    end
`ifdef PP_TIMEOUT_EN
                    else if (frame_tick) begin
                        if (armed_cnt == ToW'(TIMEOUT_FRAMES - 1)) begin
                            eaten     <= 1'b1;
                            armed_cnt <= '0;
                            cool_cnt  <= '0;
                            state     <= StCooldown;
                        end else begin
                            armed_cnt <= armed_cnt + ToW'(1);
                        end
                    end
`endif
                end
                StEffect: begin
                    if (frame_tick) begin
                        if (frames_left == 10'd1) begin
                            frames_left   <= '0;
                            effect_active <= 1'b0;
                            cool_cnt      <= '0;
                            state         <= StCooldown;
                        end else begin
                            frames_left <= frames_left - 10'd1;
                        end
                    end
                end
                default: state <= StCooldown;
            endcase
        end
    end

endmodule

// File: tb/tb_power_pack_ctrl.sv
// Directed self-checking bench for power_pack_ctrl with default parameters.
// The timeout scenario is exercised only when PP_TIMEOUT_EN is defined.
module tb_power_pack_ctrl;

    localparam int COOL   = 120;
    localparam int EFFECT = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [10:0] px;
    logic [9:0]  py;
    logic        owner;
    logic [10:0] rx;
    logic [9:0]  ry;
    logic [1:0]  mode;
    logic        spawn;
    logic        eaten;
    logic        effect_active;
    logic [1:0]  effect_mode;
    logic        effect_owner;
    logic        extra_pulse;
    logic [9:0]  frames_left;

    int n_cmp = 0;
    int n_bad = 0;

    power_pack_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .px           (px),
        .py           (py),
        .owner        (owner),
        .rx           (rx),
        .ry           (ry),
        .mode         (mode),
        .spawn        (spawn),
        .eaten        (eaten),
        .effect_active(effect_active),
        .effect_mode  (effect_mode),
        .effect_owner (effect_owner),
        .extra_pulse  (extra_pulse),
        .frames_left  (frames_left)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Runs a full cooldown and expects exactly one spawn pulse on the last tick.
    task automatic run_cooldown(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < COOL - 1; i++) begin
            tick();
            if (spawn || eaten) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_early_pulse: got %b expected 0", name, seen);
        end
        tick();
        n_cmp++;
        if (spawn !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_spawn: got %b expected 1", name, spawn);
        end
        n_cmp++;
        if (eaten !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_spawn_eaten: got %b expected 0", name, eaten);
        end
        step();
        n_cmp++;
        if (spawn !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_spawn_width: got %b expected 0", name, spawn);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({spawn, eaten, effect_active, effect_mode, effect_owner, extra_pulse} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {spawn, eaten, effect_active, effect_mode, effect_owner, extra_pulse});
        end
        n_cmp++;
        if (frames_left !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_frames_left: got %0d expected 0", frames_left);
        end
        reset = 1'b0;
    endtask

    task automatic test_spawn_timing();
        run_cooldown("spawn_timing");
    endtask

    task automatic test_boost_hit();
        rx = 11'd700; ry = 10'd500; mode = 2'b01; owner = 1'b1;
        px = 11'd600; py = 10'd505;
        step();
        n_cmp++;
        if (eaten !== 1'b0) begin
            n_bad++;
            $display("FAIL boost_far_eaten: got %b expected 0", eaten);
        end
        px = 11'd690;
        step();
        n_cmp++;
        if (eaten !== 1'b1 || effect_active !== 1'b1 || extra_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL boost_hit_flags: got eaten=%b active=%b extra=%b expected 1 1 0",
                     eaten, effect_active, extra_pulse);
        end
        n_cmp++;
        if (effect_mode !== 2'b01 || effect_owner !== 1'b1) begin
            n_bad++;
            $display("FAIL boost_latch: got mode=%b owner=%b expected 01 1", effect_mode,
                     effect_owner);
        end
        n_cmp++;
        if (frames_left !== 10'd300) begin
            n_bad++;
            $display("FAIL boost_frames_load: got %0d expected 300", frames_left);
        end
        step();
        n_cmp++;
        if (eaten !== 1'b0) begin
            n_bad++;
            $display("FAIL boost_eaten_width: got %b expected 0", eaten);
        end
        px = 11'd0;
        tick();
        n_cmp++;
        if (frames_left !== 10'd299) begin
            n_bad++;
            $display("FAIL boost_first_dec: got %0d expected 299", frames_left);
        end
        for (int i = 0; i < EFFECT - 2; i++) tick();
        n_cmp++;
        if (frames_left !== 10'd1 || effect_active !== 1'b1) begin
            n_bad++;
            $display("FAIL boost_last_frame: got left=%0d active=%b expected 1 1", frames_left,
                     effect_active);
        end
        tick();
        n_cmp++;
        if (frames_left !== 10'd0 || effect_active !== 1'b0) begin
            n_bad++;
            $display("FAIL boost_end: got left=%0d active=%b expected 0 0", frames_left,
                     effect_active);
        end
        run_cooldown("boost_cooldown");
    endtask

    task automatic test_edge();
        logic seen;
        mode = 2'b00; owner = 1'b0;
        px = 11'd684; py = 10'd505;
        step();
        step();
        n_cmp++;
        if (eaten !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_touch_eaten: got %b expected 0", eaten);
        end
        px = 11'd685;
        step();
        n_cmp++;
        if (eaten !== 1'b1 || effect_mode !== 2'b00 || effect_owner !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_overlap_hit: got eaten=%b mode=%b owner=%b expected 1 00 0",
                     eaten, effect_mode, effect_owner);
        end
        // Puck stays on the pack through the effect; no further collection may occur.
        seen = 1'b0;
        for (int i = 0; i < EFFECT; i++) begin
            tick();
            if (eaten) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || effect_active !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_overlap_ignored: got eaten_seen=%b active=%b expected 0 0", seen,
                     effect_active);
        end
        px = 11'd0;
        run_cooldown("edge_cooldown");
    endtask

    task automatic test_extra();
        mode = 2'b10; owner = 1'b0;
        px = 11'd690; py = 10'd505;
        step();
        n_cmp++;
        if (eaten !== 1'b1 || extra_pulse !== 1'b1 || effect_active !== 1'b0) begin
            n_bad++;
            $display("FAIL extra_hit: got eaten=%b extra=%b active=%b expected 1 1 0", eaten,
                     extra_pulse, effect_active);
        end
        n_cmp++;
        if (effect_mode !== 2'b10 || frames_left !== 10'd0) begin
            n_bad++;
            $display("FAIL extra_latch: got mode=%b left=%0d expected 10 0", effect_mode,
                     frames_left);
        end
        px = 11'd0;
        step();
        n_cmp++;
        if (eaten !== 1'b0 || extra_pulse !== 1'b0 || effect_active !== 1'b0) begin
            n_bad++;
            $display("FAIL extra_width: got eaten=%b extra=%b active=%b expected 0 0 0", eaten,
                     extra_pulse, effect_active);
        end
        run_cooldown("extra_cooldown");
    endtask

    task automatic test_hit_with_tick();
        mode = 2'b11; owner = 1'b1;
        px = 11'd690; py = 10'd505;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n_cmp++;
        if (frames_left !== 10'd300 || effect_active !== 1'b1) begin
            n_bad++;
            $display("FAIL tick_hit_load: got left=%0d active=%b expected 300 1", frames_left,
                     effect_active);
        end
        px = 11'd0;
        for (int i = 0; i < 150; i++) tick();
        n_cmp++;
        if (frames_left !== 10'd150) begin
            n_bad++;
            $display("FAIL tick_hit_mid: got %0d expected 150", frames_left);
        end
    endtask

    task automatic test_reset_mid_effect();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({spawn, eaten, effect_active, effect_mode, effect_owner, extra_pulse} !== 7'b0 ||
            frames_left !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_mid_effect: got flags=%b left=%0d expected 0000000 0",
                     {spawn, eaten, effect_active, effect_mode, effect_owner, extra_pulse},
                     frames_left);
        end
        step();
        reset = 1'b0;
        run_cooldown("reset_cooldown");
    endtask

`ifdef PP_TIMEOUT_EN
    task automatic test_timeout();
        logic seen;
        px = 11'd0; py = 10'd0;
        seen = 1'b0;
        for (int i = 0; i < 599; i++) begin
            tick();
            if (eaten) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got %b expected 0", seen);
        end
        tick();
        n_cmp++;
        if (eaten !== 1'b1 || effect_active !== 1'b0 || extra_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_hide: got eaten=%b active=%b extra=%b expected 1 0 0", eaten,
                     effect_active, extra_pulse);
        end
        run_cooldown("timeout_cooldown");
    endtask
`endif

    initial begin
        reset = 1'b1; frame_tick = 1'b0;
        px = 11'd0; py = 10'd0; owner = 1'b0;
        rx = 11'd700; ry = 10'd500; mode = 2'b00;
        test_reset();
        test_spawn_timing();
        test_boost_hit();
        test_edge();
        test_extra();
        test_hit_with_tick();
        test_reset_mid_effect();
`ifdef PP_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
